// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan display.
// Segment vectors are ordered {CA,CB,CC,CD,CE,CF,CG} and are active-low.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    localparam int MAX_DIGITS = 8;

    // Hex glyphs 0..F; entry n is the active-low pattern for value n.
    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100,
        7'b0001000,
        7'b1100000,
        7'b0110001,
        7'b1000010,
        7'b0110000,
        7'b0111000
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output seg_t       seg_o
);

    assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/seg_scan_mux.sv
// Round-robin scanner for up to eight 7-segment digits with per-slot blanking
// and double-buffered display data that only changes on frame boundaries.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [31:0] hex_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        load,
    output logic [7:0]  AN,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic        frame_tick
);

    localparam int SW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(TICKS_PER_DIGIT - 1);
    localparam logic [SW-1:0] SLOT_LIT  = SW'(BLANK_TICKS);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    idx_q, idx_d;

    logic [31:0]   pend_hex_q, pend_hex_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic [7:0]    pend_en_q, pend_en_d;
    logic          pend_valid_q, pend_valid_d;

    logic [31:0]   shd_hex_q, shd_hex_d;
    logic [7:0]    shd_dp_q, shd_dp_d;
    logic [7:0]    shd_en_q, shd_en_d;

    logic [7:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic          slot_last;
    logic          boundary;
    logic [3:0]    cur_digit;
    seg_t          cur_seg;

    assign slot_last = (slot_q == SLOT_LAST);
    assign boundary  = slot_last && (idx_q == IDX_LAST);
    assign cur_digit = shd_hex_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .digit_i (cur_digit),
        .seg_o   (cur_seg)
    );

    always_comb begin
        slot_d = slot_last ? '0 : slot_q + SW'(1);
        idx_d  = idx_q;
        if (slot_last) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // A load on the boundary cycle bypasses pending and lands in shadow directly.
    always_comb begin
        pend_hex_d   = pend_hex_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        shd_hex_d    = shd_hex_q;
        shd_dp_d     = shd_dp_q;
        shd_en_d     = shd_en_q;
        if (load) begin
            pend_hex_d   = hex_in;
            pend_dp_d    = dp_in;
            pend_en_d    = en_in;
            pend_valid_d = 1'b1;
        end
        if (boundary) begin
            pend_valid_d = 1'b0;
            if (load) begin
                shd_hex_d = hex_in;
                shd_dp_d  = dp_in;
                shd_en_d  = en_in;
            end else if (pend_valid_q) begin
                shd_hex_d = pend_hex_q;
                shd_dp_d  = pend_dp_q;
                shd_en_d  = pend_en_q;
            end
        end
    end

    always_comb begin
        an_d   = 8'hFF;
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        tick_d = boundary;
        if ((slot_q >= SLOT_LIT) && shd_en_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_seg;
            dp_d        = ~shd_dp_q[idx_q];
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            slot_q       <= '0;
            idx_q        <= '0;
            pend_hex_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            shd_hex_q    <= '0;
            shd_dp_q     <= '0;
            shd_en_q     <= '0;
            an_q         <= 8'hFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pend_hex_q   <= pend_hex_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            shd_hex_q    <= shd_hex_d;
            shd_dp_q     <= shd_dp_d;
            shd_en_q     <= shd_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
        end
    end

    assign AN         = an_q;
    assign CA         = seg_q[6];
    assign CB         = seg_q[5];
    assign CC         = seg_q[4];
    assign CD         = seg_q[3];
    assign CE         = seg_q[2];
    assign CF         = seg_q[1];
    assign CG         = seg_q[0];
    assign DP         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexed scanner that drives up to eight 7-segment digits through the board's shared cathode lines (CA..CG, DP) and per-digit anodes (AN). It sits directly downstream of the hex-digit producers (adders and other datapath blocks) and replaces the static single-digit drive. It latches a 32-bit hex word plus per-digit enable and decimal-point masks, then refreshes the digits round-robin. Each digit slot has a blanking interval to suppress ghosting, and new data is applied only at frame boundaries.

Parameters:
NUM_DIGITS, 8, number of scanned digits (1..8); AN bits at index NUM_DIGITS and above are held at 1.
TICKS_PER_DIGIT, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal values are 2 or more.
BLANK_TICKS, 1000, cycles at the start of each slot with all anodes off; legal range is 1 to TICKS_PER_DIGIT-1.

Ports:
CLK100MHZ  in  1  system clock; the only clock.
CPU_RESETN  in  1  reset, asynchronous, active-low.
hex_in  in  32  digit values; digit i is hex_in[4i+3:4i].
dp_in  in  8  decimal-point request per digit (1 = lit).
en_in  in  8  digit enable (1 = digit shown, 0 = blank).
load  in  1  single-cycle request to capture hex_in, dp_in and en_in.
AN  out  8  anode select, active-low.
CA, CB, CC, CD, CE, CF, CG  out  1 each  segments a..g, active-low.
DP  out  1  decimal point, active-low.
frame_tick  out  1  one-cycle pulse on each frame boundary.

Behaviour:
- Reset (async assert on CPU_RESETN=0):
  - AN=8'hFF, CA..CG=1, DP=1, frame_tick=0.
  - Shadow and pending registers cleared; pending_valid=0.
  - Slot counter=0, digit index=0.
  - Effect is immediate, including mid-frame.
- Timing counters:
  - Slot counter runs 0..TICKS_PER_DIGIT-1 and wraps to 0.
  - On each wrap, the digit index advances 0..NUM_DIGITS-1 and wraps.
  - Frame boundary = the cycle where slot counter = TICKS_PER_DIGIT-1 and index = NUM_DIGITS-1.
  - Frame period = NUM_DIGITS*TICKS_PER_DIGIT cycles.
- Load path (double-buffered):
  - load=1 captures all inputs into pending and sets pending_valid.
  - If several loads occur in one frame, the last one wins.
  - At a frame boundary, if load or pending_valid is set, the shadow registers take (load ? inputs : pending) and pending_valid clears.
  - A load on the boundary cycle is therefore applied at that same boundary.
  - Shadow registers never change except at a boundary or on reset.
- frame_tick: registered; equals 1 for exactly the one cycle after each boundary, whether or not an update occurred.
- Output generation (all outputs registered; one cycle of latency from counter state):
  - Slot counter < BLANK_TICKS: AN=8'hFF, CA..CG=1, DP=1.
  - Otherwise, with i = digit index: AN[i]=~en_shadow[i] and all other AN bits = 1.
  - If en_shadow[i]=1: segments = decode(shadow digit i) and DP = ~dp_shadow[i].
  - If en_shadow[i]=0: segments and DP are all 1.
- Decode (CA..CG order, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- At most one AN bit is low at any time.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF = 7'b1111111.
  - The 16-entry hex-to-segment constant table.
  - A typedef for the 7-bit active-low segment vector.
- Sub-module hex_to_7seg: purely combinational 4-to-7 decoder built from the table; instantiated once on the muxed digit.
- Counters, load buffering and output registers live in seg_scan_mux.

Test Plan:
(Use NUM_DIGITS=8, TICKS_PER_DIGIT=8, BLANK_TICKS=2 unless stated.)
- Reset then idle with no load:
  - AN=FF, CA..CG=1111111, DP=1 throughout.
  - frame_tick pulses every 64 cycles.
- load once with hex_in=32'h76543210, en_in=FF, dp_in=01:
  - After the next frame_tick, slot 0 shows AN=FE, segments 0000001, DP=0 for slot cycles 2..7 (plus one cycle of latency).
  - Slot 0 is blanked (AN=FF) during cycles 0..1.
  - Slot 7 shows AN=7F, segments 0001111, DP=1.
- Two loads within one frame (hex 8888_8888, then FFFF_FFFF):
  - Display is unchanged until frame_tick.
  - Afterwards all digits show 0111000; 8 never appears.
- load with en_in=05 and hex=AAAA_AAAA:
  - AN goes low only in slots 0 (FE) and 2 (FB), with segments 0001000.
  - All other slots show AN=FF and segments 1111111.
- Deassert CPU_RESETN mid-slot while a digit is lit:
  - AN=FF and segments off asynchronously, in the same cycle.
  - After release, the display stays blank until a new load plus a boundary.
- Rebuild with NUM_DIGITS=4, then load en_in=FF:
  - AN[7:4] stay 1 forever.
  - frame_tick period is 32 cycles.
  - Digits cycle through AN=FE, FD, FB, F7.
